hazard_forward_unit: RTL and testbench

//   Combined operand-forwarding and load-use hazard unit for the 5-stage RV32 pipeline.
//   - Selects EX-stage operand sources from EX/MEM or MEM/WB, with EX/MEM taking priority.
//   - Detects load-use hazards in ID and stalls PC and IF/ID while injecting ID/EX bubbles
//     for a parametrised number of cycles. A small state machine tracks the stall.

---
 rtl/hazard_forward_unit.sv | 146 ++++++++++++++
 tb/tb_hazard_forward_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Operand-forwarding and load-use hazard unit for a 5-stage RV32 pipeline.
//   Forwarding muxes select the EX operand sources combinationally (EX/MEM
//   beats MEM/WB, x0 never forwards). A load in ID/EX whose rd is read by
//   the instruction in IF/ID stalls PC and IF/ID and injects ID/EX bubbles
//   for LOAD_LAT consecutive cycles. The first cycle is driven directly from
//   the hazard; the rest are tracked by a two-state machine with a counter.
//
//   Optional build macro: HFU_PERF_EN adds a 32-bit stall-cycle counter and
//   the stall_cycles output.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      branch/jump flush from EX, aborts any stall
//   id_rs1/id_rs2              source registers of the IF/ID instruction
//   id_use_rs1/id_use_rs2      IF/ID instruction actually reads rs1/rs2
//   ex_rs1/ex_rs2/ex_rd        ID/EX register indices
//   ex_mem_read                ID/EX holds a load
//   mem_rd, mem_reg_write      EX/MEM destination and write enable
//   wb_rd, wb_reg_write        MEM/WB destination and write enable
//   forward_a/forward_b        00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_pc, stall_if_id      hold PC / IF/ID
//   bubble_id_ex               zero ID/EX control
//   stall_cycles               stall-cycle count (HFU_PERF_EN only)
module hazard_forward_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall_pc,
  output logic              stall_if_id,
`ifdef HFU_PERF_EN
  output logic              bubble_id_ex,
  output logic [31:0]       stall_cycles
`else
  output logic              bubble_id_ex
`endif
);

  typedef enum logic {IDLE, STALL} state_t;

  // Cycles still owed after the first (combinational) stall cycle, minus one.
  localparam logic [1:0] CNT_INIT = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        hz;
  logic        stall;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] m_rd,
                                         input logic              m_we,
                                         input logic [REG_AW-1:0] w_rd,
                                         input logic              w_we);
    if (m_we && (m_rd != '0) && (m_rd == src))
      return 2'b10;
    else if (w_we && (w_rd != '0) && (w_rd == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign hz = ex_mem_read && (ex_rd != '0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // In STALL the ID/EX stage already holds a bubble, so hz is ignored there.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else if (hz) begin
          stall = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = STALL;
            cnt_d   = CNT_INIT;
          end
        end
      end
      STALL: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          stall = 1'b1;
          if (cnt_q == 2'd0) state_d = IDLE;
          else               cnt_d   = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Outputs are gated by rst_n so they drop the moment reset asserts.
  assign stall_pc     = rst_n & stall;
  assign stall_if_id  = rst_n & stall;
  assign bubble_id_ex = rst_n & stall;
  assign forward_a    = rst_n ? fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write) : 2'b00;
  assign forward_b    = rst_n ? fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write) : 2'b00;

`ifdef HFU_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        perf_cnt <= 32'd0;
    else if (stall_pc) perf_cnt <= perf_cnt + 32'd1;
  end

  assign stall_cycles = perf_cnt;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst_n, flush;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, mem_reg_write, wb_reg_write;

  logic [1:0] fa [3];
  logic [1:0] fb [3];
  logic       spc [3];
  logic       sif [3];
  logic       bub [3];
`ifdef HFU_PERF_EN
  logic [31:0] sc [3];
  logic [31:0] exp_sc [3];
`endif

  int vectors = 0;
  int miscompares = 0;
  int rem [3];

  always #5 clk = ~clk;

  // Three copies with LOAD_LAT = 1, 2, 3 share one stimulus stream.
  for (genvar g = 0; g < 3; g++) begin : u
    hazard_forward_unit #(.REG_AW(5), .LOAD_LAT(g + 1)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .forward_a(fa[g]), .forward_b(fb[g]),
      .stall_pc(spc[g]), .stall_if_id(sif[g]),
`ifdef HFU_PERF_EN
      .bubble_id_ex(bub[g]), .stall_cycles(sc[g])
`else
      .bubble_id_ex(bub[g])
`endif
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (!rst_n) return 2'b00;
    if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_hz();
    return ex_mem_read && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  // A stall cycle happens whenever cycles are still owed or a new hazard appears.
  function automatic logic ref_stall(input int k);
    return rst_n && !flush && (rem[k] > 0 || ref_hz());
  endfunction

  function automatic logic [6:0] exp_pack(input int k);
    logic s;
    s = ref_stall(k);
    return {ref_fwd(ex_rs1), ref_fwd(ex_rs2), s, s, s};
  endfunction

  function automatic logic [6:0] got_pack(input int k);
    return {fa[k], fb[k], spc[k], sif[k], bub[k]};
  endfunction

  // One clock edge: advance the model from the inputs present at the edge.
  task automatic advance();
    logic st [3];
    logic h;
    @(posedge clk);
    h = ref_hz();
    for (int k = 0; k < 3; k++) st[k] = ref_stall(k);
    for (int k = 0; k < 3; k++) begin
`ifdef HFU_PERF_EN
      if (!rst_n) exp_sc[k] = 32'd0;
      else if (st[k]) exp_sc[k] = exp_sc[k] + 32'd1;
`endif
      if (!rst_n || flush) rem[k] = 0;
      else if (rem[k] > 0) rem[k] = rem[k] - 1;
      else if (h) rem[k] = k;   // LOAD_LAT-1 more cycles after this one
    end
    #1;
  endtask

  task automatic quiet_inputs();
    flush = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0;
    mem_reg_write = 0; wb_reg_write = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
  endtask

  task automatic set_hazard();
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    for (int k = 0; k < 3; k++) rem[k] = 0;
`ifdef HFU_PERF_EN
    for (int k = 0; k < 3; k++) exp_sc[k] = 32'd0;
`endif
    advance();
    rst_n = 1;
    advance();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    for (int k = 0; k < 3; k++) rem[k] = 0;
    ex_rs1 = 5; ex_rs2 = 6; mem_rd = 5; mem_reg_write = 1; wb_rd = 6; wb_reg_write = 1;
    set_hazard();
    #2;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (got_pack(k) !== 7'b0) begin
        miscompares++;
        $display("FAIL reset dut%0d got=%b exp=%b", k, got_pack(k), 7'b0);
      end
`ifdef HFU_PERF_EN
      vectors++;
      if (sc[k] !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_perf dut%0d got=%0d exp=0", k, sc[k]);
      end
`endif
    end
    quiet_inputs();
    do_reset();
  endtask

  task automatic test_forwarding();
    quiet_inputs();
    ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1;
    #1;
    vectors++;
    if (fa[0] !== 2'b10) begin
      miscompares++; $display("FAIL fwd_priority got=%b exp=10", fa[0]);
    end
    mem_reg_write = 0; #1;
    vectors++;
    if (fa[0] !== 2'b01) begin
      miscompares++; $display("FAIL fwd_memwb got=%b exp=01", fa[0]);
    end
    mem_rd = 0; mem_reg_write = 1; ex_rs2 = 0; wb_rd = 0; #1;
    vectors++;
    if (fb[0] !== 2'b00) begin
      miscompares++; $display("FAIL fwd_x0 got=%b exp=00", fb[0]);
    end
    ex_rs2 = 9; wb_rd = 9; wb_reg_write = 1; mem_rd = 3; #1;
    vectors++;
    if (fb[2] !== 2'b01) begin
      miscompares++; $display("FAIL fwd_b_wb got=%b exp=01", fb[2]);
    end
    quiet_inputs();
    advance();
  endtask

  task automatic test_load_latency();
    int cnt [3];
    for (int k = 0; k < 3; k++) cnt[k] = 0;
    quiet_inputs();
    set_hazard();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (got_pack(k) !== exp_pack(k)) begin
          miscompares++;
          $display("FAIL latency c%0d dut%0d got=%b exp=%b", c, k, got_pack(k), exp_pack(k));
        end
        if (spc[k]) cnt[k]++;
      end
      advance();
      quiet_inputs();   // hazard present for one cycle only; then a bubble
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (cnt[k] !== k + 1) begin
        miscompares++;
        $display("FAIL stall_length dut%0d got=%0d exp=%0d", k, cnt[k], k + 1);
      end
    end
    id_use_rs2 = 0; ex_mem_read = 1; ex_rd = 7; id_rs2 = 7;
    @(negedge clk);
    vectors++;
    if (spc[0] !== 1'b0) begin
      miscompares++; $display("FAIL no_use_rs2 got=%b exp=0", spc[0]);
    end
    advance();
    quiet_inputs();
    advance();
  endtask

  task automatic test_flush();
    quiet_inputs();
    set_hazard();
    advance();
    quiet_inputs();
    flush = 1;   // stall cycle 2 of the LOAD_LAT=3 copy
    #2;
    vectors++;
    if ({spc[2], sif[2], bub[2]} !== 3'b000) begin
      miscompares++; $display("FAIL flush_now got=%b exp=000", {spc[2], sif[2], bub[2]});
    end
    advance();
    flush = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (got_pack(k) !== exp_pack(k) || spc[k] !== 1'b0) begin
          miscompares++;
          $display("FAIL flush_after c%0d dut%0d got=%b exp=%b", c, k, got_pack(k), exp_pack(k));
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_stall();
    quiet_inputs();
    set_hazard();
    advance();
    quiet_inputs();
    #2;
    vectors++;
    if (spc[2] !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_stall got=%b exp=1", spc[2]);
    end
    rst_n = 0;
    for (int k = 0; k < 3; k++) rem[k] = 0;
`ifdef HFU_PERF_EN
    for (int k = 0; k < 3; k++) exp_sc[k] = 32'd0;
`endif
    #1;
    vectors++;
    if ({spc[2], sif[2], bub[2]} !== 3'b000) begin
      miscompares++; $display("FAIL async_reset got=%b exp=000", {spc[2], sif[2], bub[2]});
    end
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      advance();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (spc[k] !== 1'b0 || got_pack(k) !== exp_pack(k)) begin
          miscompares++;
          $display("FAIL post_reset c%0d dut%0d got=%b exp=%b", c, k, got_pack(k), exp_pack(k));
        end
      end
    end
    advance();
  endtask

  task automatic test_back_to_back();
    quiet_inputs();
    set_hazard();   // hazard held: each new IDLE cycle restarts a stall
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (got_pack(k) !== exp_pack(k) || spc[k] !== 1'b1) begin
          miscompares++;
          $display("FAIL back_to_back c%0d dut%0d got=%b exp=%b", c, k, got_pack(k), exp_pack(k));
        end
      end
      advance();
    end
    quiet_inputs();
    for (int c = 0; c < 4; c++) advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd  = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
      ex_mem_read = 1'($urandom); mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (got_pack(k) !== exp_pack(k)) begin
          miscompares++;
          $display("FAIL random c%0d dut%0d got=%b exp=%b", c, k, got_pack(k), exp_pack(k));
        end
      end
      advance();
    end
    quiet_inputs();
    for (int c = 0; c < 4; c++) advance();
  endtask

`ifdef HFU_PERF_EN
  task automatic test_perf();
    quiet_inputs();
    do_reset();
    for (int h = 0; h < 2; h++) begin
      set_hazard();
      advance();
      quiet_inputs();
      for (int c = 0; c < 4; c++) advance();
    end
    vectors++;
    if (sc[1] !== 32'd4) begin
      miscompares++; $display("FAIL perf_two_hazards got=%0d exp=4", sc[1]);
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (sc[k] !== exp_sc[k]) begin
        miscompares++; $display("FAIL perf_model dut%0d got=%0d exp=%0d", k, sc[k], exp_sc[k]);
      end
    end
    @(negedge clk);
    force u[1].dut.perf_cnt = 32'hFFFF_FFFF;
    #1;
    release u[1].dut.perf_cnt;
    exp_sc[1] = 32'hFFFF_FFFF;
    set_hazard();
    advance();
    quiet_inputs();
    vectors++;
    if (sc[1] !== 32'd0) begin
      miscompares++; $display("FAIL perf_wrap got=%h exp=0", sc[1]);
    end
    for (int c = 0; c < 4; c++) advance();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    quiet_inputs();
    rst_n = 0;
    for (int k = 0; k < 3; k++) rem[k] = 0;
`ifdef HFU_PERF_EN
    for (int k = 0; k < 3; k++) exp_sc[k] = 32'd0;
`endif
    #1;
    test_reset();
    test_forwarding();
    test_load_latency();
    test_flush();
    test_reset_mid_stall();
    test_back_to_back();
    test_random();
`ifdef HFU_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
